// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared helpers for the rr_mux_n arbitrated selector.
// Optional feature macro used by the slice: RR_MUX_LOCK_EN (packet lock).
package rr_mux_pkg;

    // Largest grant vector the index encoder accepts.
    localparam int MAX_CH = 256;

    // ceil(log2(n)), but never below 1 so a single channel still has a select bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // One-hot (or zero) grant to binary index; zero grant encodes to 0.
    function automatic logic [31:0] onehot_to_idx(input logic [MAX_CH-1:0] g);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (g[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: per-channel valid/ready inputs plus the single registered output.
// RR_MUX_LOCK_EN adds the per-channel in_last packet delimiter.
interface rr_mux_n_if
    import rr_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 32
) ();
    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]       in_last;
`endif
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    // Sources plus consumer (testbench / surrounding fabric).
    modport master (
        output in_valid, in_data, out_ready,
`ifdef RR_MUX_LOCK_EN
        output in_last,
`endif
        input  in_ready, out_valid, out_data, out_sel
    );

    // The selector itself.
    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef RR_MUX_LOCK_EN
        input  in_last,
`endif
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_n_arbiter.sv
// rr_arbiter: round-robin / fixed-priority grant generator; owns the rr pointer.
// Unaffected by RR_MUX_LOCK_EN (the top masks req and gates advance instead).
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int SEL_W = clog2_min1(N);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] gnt_idx;

    // First requester searching from ptr (rr) or from 0 (fixed), wrapping mod N.
    always_comb begin
        int  start;
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        start = rr_mode ? int'(ptr_q) : 0;
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt_idx = SEL_W'(onehot_to_idx(MAX_CH'(grant)));

    // Pointer moves past the served channel only on an rr-mode transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && rr_mode) begin
            ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register, channel 0 highest priority out of reset.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel arbitrated selector with a one-entry output register.
// Macro RR_MUX_LOCK_EN: holds the grant on a channel until its in_last beat.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rr_mode,
    rr_mux_n_if.slave  bus
);
    localparam int SEL_W = clog2_min1(N);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;

    logic             load;
    logic             xfer;
    logic             advance;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] sel_data;

    assign load    = !out_valid_q || bus.out_ready;
    assign gnt_idx = SEL_W'(onehot_to_idx(MAX_CH'(grant)));
    assign xfer    = |bus.in_ready;

`ifdef RR_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic             last_beat;

    // Mask requests down to the locked channel while a packet is open.
    always_comb begin
        req       = bus.in_valid;
        last_beat = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lock_q && (SEL_W'(i) != lock_idx_q)) req[i] = 1'b0;
            if (grant[i]) last_beat = bus.in_last[i];
        end
    end

    assign advance = xfer && last_beat;

    // Open the lock on a non-last beat, release it on the last one.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            lock_d     = !last_beat;
            lock_idx_d = gnt_idx;
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    assign req     = bus.in_valid;
    assign advance = xfer;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rr_mode (rr_mode),
        .advance (advance),
        .grant   (grant)
    );

    // Ready only to the granted channel, and only when the register can load.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = load && grant[i] && !rst;
        end
    end

    // AND-OR data select from the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register next state: load a beat, go idle, or hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_sel_d  = gnt_idx;
            end
        end
    end

    // Output register; a beat held during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed bench for rr_mux_n (N=8, WIDTH=32).
// Exercises the RR_MUX_LOCK_EN packet lock when that macro is defined.
module tb_rr_mux_n;
    localparam int N     = 8;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    logic rr_mode;
    int   checks;
    int   errors;

    rr_mux_n_if #(.N(N), .WIDTH(WIDTH)) bus ();

    rr_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (rr_mode),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [2:0] s);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
        chk({tag, "_data"},  64'(bus.out_data),  64'(d));
        chk({tag, "_sel"},   64'(bus.out_sel),   64'(s));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        rr_mode       = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        bus.in_last   = '1;
`endif
        for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = 32'hA000_0000 | 32'(i);

        // Reset state, and no ready while rst is high.
        @(negedge clk);
        tick();
        chk_out("reset", 1'b0, 32'h0, 3'd0);
        bus.in_valid = 8'hFF;
        #1 chk("rst_ready", 64'(bus.in_ready), 64'h00);

        // Round-robin sweep: 0..7 then wrap to 0, one beat per cycle.
        rst = 1'b0;
        #1 chk("rr_ready0", 64'(bus.in_ready), 64'h01);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_out("rr_beat", 1'b1, 32'hA000_0000 | 32'(k % 8), 3'(k % 8));
            chk("rr_ready", 64'(bus.in_ready), 64'(8'h01 << ((k + 1) % 8)));
        end

        // Fixed priority with 1010_0100: ch2, then ch5, then ch7.
        rr_mode      = 1'b0;
        bus.in_valid = 8'b1010_0100;
        #1 chk("fp_ready2", 64'(bus.in_ready), 64'h04);
        tick();
        chk_out("fp_beat2", 1'b1, 32'hA000_0002, 3'd2);
        bus.in_valid = 8'b1010_0000;
        #1 chk("fp_ready5", 64'(bus.in_ready), 64'h20);
        tick();
        chk_out("fp_beat5", 1'b1, 32'hA000_0005, 3'd5);
        bus.in_valid = 8'b1000_0000;
        #1 chk("fp_ready7", 64'(bus.in_ready), 64'h80);
        tick();
        chk_out("fp_beat7", 1'b1, 32'hA000_0007, 3'd7);

        // Back to rr: pointer preserved at 1, so ch3 alone is taken; ptr -> 4.
        rr_mode      = 1'b1;
        bus.in_valid = 8'h08;
        tick();
        chk_out("st_load3", 1'b1, 32'hA000_0003, 3'd3);

        // Stall for 4 cycles: output holds, no ready anywhere.
        bus.out_ready = 1'b0;
        bus.in_valid  = 8'h01;
        for (int k = 0; k < 4; k++) begin
            #1 chk("st_ready", 64'(bus.in_ready), 64'h00);
            tick();
            chk_out("st_hold", 1'b1, 32'hA000_0003, 3'd3);
        end
        bus.out_ready = 1'b1;
        #1 chk("st_drain_ready", 64'(bus.in_ready), 64'h01);
        tick();
        chk_out("st_drain", 1'b1, 32'hA000_0000, 3'd0);

        // Idle: valid drops, data/sel hold; pointer stays at 1.
        bus.in_valid = '0;
        tick();
        chk_out("idle1", 1'b0, 32'hA000_0000, 3'd0);
        tick();
        chk_out("idle2", 1'b0, 32'hA000_0000, 3'd0);
        bus.in_valid = 8'hFF;
        #1 chk("idle_ptr_ready", 64'(bus.in_ready), 64'h02);
        tick();
        chk_out("idle_next", 1'b1, 32'hA000_0001, 3'd1);

        // Reset while out_valid=1: beat dropped, pointer back to 0.
        rst = 1'b1;
        #1 chk("rst2_ready", 64'(bus.in_ready), 64'h00);
        tick();
        chk_out("rst2", 1'b0, 32'h0, 3'd0);
        rst = 1'b0;
        #1 chk("rst2_ready0", 64'(bus.in_ready), 64'h01);
        tick();
        chk_out("rst2_first", 1'b1, 32'hA000_0000, 3'd0);

`ifdef RR_MUX_LOCK_EN
        // Pointer now 1: ch1 sends a 3-beat packet while ch0/ch2 wait.
        bus.in_valid = 8'h07;
        bus.in_last  = 8'h00;
        for (int k = 0; k < 2; k++) begin
            #1 chk("lk_ready", 64'(bus.in_ready), 64'h02);
            tick();
            chk_out("lk_beat", 1'b1, 32'hA000_0001, 3'd1);
        end
        bus.in_last = 8'h02;
        #1 chk("lk_ready_last", 64'(bus.in_ready), 64'h02);
        tick();
        chk_out("lk_beat_last", 1'b1, 32'hA000_0001, 3'd1);
        bus.in_last = 8'hFF;
        #1 chk("lk_ready_ch2", 64'(bus.in_ready), 64'h04);
        tick();
        chk_out("lk_ch2", 1'b1, 32'hA000_0002, 3'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised N-channel, WIDTH-bit arbitrated selector; successor to the fixed 8-way combinational mux.
- Replaces the external select with an internal arbiter: round-robin, or fixed priority when rr_mode=0.
- Valid/ready handshake on every input channel and on the single output.
- One-entry output register: sources are decoupled from the consumer and throughput is one beat per cycle. Used where several datapath/memory sources share one consumer port.

Parameters:
WIDTH, 32, data bits per channel
N, 8, number of input channels (>=1)
SEL_W, $clog2(N) (1 when N=1), width of out_sel; localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
in_valid  in  N  per-channel valid
in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  out  N  per-channel ready (combinational)
out_valid  out  1  registered output valid
out_data  out  WIDTH  registered output data
out_sel  out  SEL_W  index of the channel whose beat is in out_data
out_ready  in  1  consumer ready

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer=0 (channel 0 highest priority).
  - A beat held in the register during reset is dropped.
  - in_ready=0 while rst=1.
- load = !out_valid || out_ready.
  - The register may accept a new beat in the same cycle the old beat drains.
  - No bubble at full throughput.
- Grant (combinational, one-hot or zero) is computed over in_valid.
  - Fixed priority: lowest asserted index wins.
  - Round-robin: first asserted index searching ptr, ptr+1, ..., wrapping mod N.
- in_ready[i] = load && grant[i] && !rst. At most one in_ready is high per cycle.
- Transfer on channel g: in_valid[g] && in_ready[g].
  - Next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Round-robin pointer update:
  - On a transfer from g: ptr <= (g==N-1) ? 0 : g+1.
  - Pointer is unchanged when there is no transfer, or when rr_mode=0.
- If load=1 and no input is valid: out_valid <= 0 and out_data/out_sel hold their last values.
- If out_valid=1 && !out_ready: out_data, out_sel and out_valid hold, and all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Sources must not make in_valid depend on in_ready. Once asserted, in_valid and in_data are held until transfer.
- rr_mode changes take effect on the next arbitration; the pointer is preserved across mode changes.
- N=1: out_sel is constant 0 and the block degenerates to a one-entry pipeline register.
- Round-robin starvation bound: a continuously valid channel is granted within N transfers.

Optional Feature:
- Macro: RR_MUX_LOCK_EN.
- Defined:
  - Adds input in_last [N].
  - After a transfer from g with in_last[g]=0, the grant is locked to g.
  - Other channels are ignored until a transfer from g with in_last[g]=1.
  - The pointer advances only on that last beat.
  - Reset clears the lock.
- Undefined:
  - No in_last port.
  - Arbitration happens independently on every beat.

Decomposition:
- Package rr_mux_pkg: function for clog2-with-minimum-1 and a grant-to-index encoder function.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs req, rr_mode, advance; output grant.
  - Owns the pointer.
- rr_mux_n holds the output register, handshake logic and the data select.

Test Plan:
- Reset, then N=8, rr_mode=1, all in_valid=1, out_ready=1 held → out_sel sequence 0,1,...,7,0, one beat per cycle; out_data = channel tag (e.g. 32'hA000_000i).
- rr_mode=0, in_valid=8'b1010_0100 → only channel 2 sees in_ready. After ch2 drops, channel 5 wins; channel 7 is served last.
- Output stall: beat from ch3 loaded, out_ready=0 for 4 cycles → out_data/out_sel stable, all in_ready=0. out_ready=1 → new beat loads in the same cycle as the drain.
- Idle: all in_valid=0 with out_ready=1 → out_valid falls after 1 cycle; pointer unchanged, verified on the next grant.
- rst=1 for one cycle while out_valid=1 → next cycle out_valid=0, out_data=0, out_sel=0; the first grant after reset goes to ch0.
- RR_MUX_LOCK_EN: ch1 sends 3 beats, last on the 3rd, while ch0/ch2 are valid → ch1,ch1,ch1,ch2 order.
